// File: rtl/irq_ctrl_cpu.sv
// Interrupt controller with a 4-byte CPU register window: PENDING, ENABLE, EDGE_SEL, VECTOR.
// Define IRQ_CTRL_VECTOR_EN to build the VECTOR priority encoder; otherwise VECTOR reads 0.

module irq_ctrl_cpu_bit (
  input  logic clk_i,
  input  logic reset_i,
  input  logic src_i,
  input  logic edge_sel_i,
  input  logic sel_chg_i,
  input  logic clr_i,
  output logic pend_o
);
  logic s1, s2, s3;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      pend_o <= 1'b0;
    end else begin
      s1 <= src_i;
      s2 <= s1;
      s3 <= s2;
      // a mode change wipes the bit; in edge mode a new edge beats a same-cycle clear
      if (sel_chg_i)                pend_o <= 1'b0;
      else if (!edge_sel_i)         pend_o <= s2;
      else if (s2 && !s3)           pend_o <= 1'b1;
      else if (clr_i)               pend_o <= 1'b0;
    end
  end
endmodule

module irq_ctrl_cpu #(
  parameter int BaseAddress   = 'h9010,
  parameter int address_width = 16,
  parameter int data_width    = 8,
  parameter int NumSources    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  input  logic [NumSources-1:0]    irq_src_i,
  output logic                     irq_o
);
  localparam logic [address_width-1:0] BASE = address_width'(BaseAddress);

  logic [address_width-1:0] offset;
  logic                     in_win, wr_en, rd_en;
  logic [1:0]               reg_sel;
  logic [NumSources-1:0]    wdata, pending, enable, edge_sel, clr, sel_chg, masked;
  logic [data_width-1:0]    vector;

  // unsigned wrap makes addresses below BASE land far outside the window
  assign offset  = address_i - BASE;
  assign in_win  = offset < address_width'(4);
  assign wr_en   = in_win && rd_wr_i;
  assign rd_en   = in_win && !rd_wr_i;
  assign reg_sel = offset[1:0];
  assign wdata   = data_i[NumSources-1:0];
  assign clr     = (wr_en && reg_sel == 2'd0) ? wdata : '0;
  assign sel_chg = (wr_en && reg_sel == 2'd2) ? (wdata ^ edge_sel) : '0;
  assign masked  = pending & enable;

  irq_ctrl_cpu_bit u_bit [NumSources-1:0] (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .src_i      (irq_src_i),
    .edge_sel_i (edge_sel),
    .sel_chg_i  (sel_chg),
    .clr_i      (clr),
    .pend_o     (pending)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      enable   <= '0;
      edge_sel <= '0;
    end else if (wr_en) begin
      if (reg_sel == 2'd1) enable   <= wdata;
      if (reg_sel == 2'd2) edge_sel <= wdata;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) irq_o <= 1'b0;
    else         irq_o <= |masked;
  end

`ifdef IRQ_CTRL_VECTOR_EN
  // scan high to low so the lowest set bit is the last assignment
  always_comb begin
    vector = '0;
    for (int i = NumSources - 1; i >= 0; i--) begin
      if (masked[i]) begin
        vector                 = '0;
        vector[data_width-1]   = 1'b1;
        vector[data_width-2:0] = (data_width-1)'(i);
      end
    end
  end
`else
  assign vector = '0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) data_o <= '0;
    else if (rd_en) begin
      case (reg_sel)
        2'd0:    data_o <= data_width'(pending);
        2'd1:    data_o <= data_width'(enable);
        2'd2:    data_o <= data_width'(edge_sel);
        default: data_o <= vector;
      endcase
    end
  end
endmodule
